// File: rtl/sc_statemachinescroll_pkg.sv
// Shared game definitions: FSM encodings, shift codes, level limit and the
// state-to-output decode used by the scroll state machine.
package sc_statemachinescroll_pkg;

   localparam logic [2:0] ST_RESET        = 3'd0;
   localparam logic [2:0] ST_IDLE         = 3'd1;
   localparam logic [2:0] ST_INIT         = 3'd2;
   localparam logic [2:0] ST_WAIT_RELEASE = 3'd3;
   localparam logic [2:0] ST_RUN          = 3'd4;
   localparam logic [2:0] ST_SHIFT        = 3'd5;
   localparam logic [2:0] ST_LOAD         = 3'd6;
   localparam logic [2:0] ST_GAMEOVER     = 3'd7;

   localparam logic [1:0] SEL_HOLD  = 2'b11;
   localparam logic [1:0] SEL_DOWN  = 2'b10;
   localparam logic [1:0] LEVEL_MAX = 2'd3;

   localparam int TICK_W = 24;

   typedef struct packed {
      logic       clear_n;
      logic       load_n;
      logic [1:0] shift_sel;
      logic       gameover;
   } scroll_ctl_t;

   localparam scroll_ctl_t CTL_IDLE = '{clear_n: 1'b1, load_n: 1'b1,
                                        shift_sel: SEL_HOLD, gameover: 1'b0};

   function automatic logic [TICK_W-1:0] scroll_period(input logic [TICK_W-1:0] base,
                                                        input logic [1:0] level);
      return base >> level;
   endfunction

   // Moore decode: every control output depends on the state alone.
   function automatic scroll_ctl_t decode_ctl(input logic [2:0] state);
      scroll_ctl_t ctl;
      ctl = CTL_IDLE;
      case (state)
         ST_INIT:     ctl.clear_n   = 1'b0;
         ST_SHIFT:    ctl.shift_sel = SEL_DOWN;
         ST_LOAD:     ctl.load_n    = 1'b0;
         ST_GAMEOVER: ctl.gameover  = 1'b1;
         default:     ctl = CTL_IDLE;
      endcase
      return ctl;
   endfunction

endpackage

// File: rtl/sc_statemachinescroll_scrolltick.sv
// Scroll-rate prescaler: counts enabled cycles and flags the terminal count
// of the current period, restarting from zero on that cycle.
module sc_scrolltick
   import sc_statemachinescroll_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              clear,
   input  logic [TICK_W-1:0] period,
   output logic              terminal
);

   localparam logic [TICK_W-1:0] ONE = TICK_W'(1);

   logic [TICK_W-1:0] count;

   // Greater-or-equal so a period shortened by a level change is never skipped past.
   assign terminal = enable && (count >= (period - ONE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear || terminal) begin
         count <= '0;
      end else if (enable) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/sc_statemachinescroll.sv
// Scroll-game control FSM: start/clear handshake, timed row shifts, periodic
// obstacle loads, speed levels and collision game-over.
module sc_statemachinescroll
   import sc_statemachinescroll_pkg::*;
#(
   parameter int PERIOD0        = 12_500_000,
   parameter int ROWS_PER_LOAD  = 4,
   parameter int ROWS_PER_LEVEL = 64
) (
   input  logic       SC_STATEMACHINESCROLL_CLOCK_50,
   input  logic       SC_STATEMACHINESCROLL_RESET_InHigh,
   input  logic       SC_STATEMACHINESCROLL_startButton_InLow,
   input  logic       SC_STATEMACHINESCROLL_collision_InLow,
   output logic       SC_STATEMACHINESCROLL_clear_OutLow,
   output logic       SC_STATEMACHINESCROLL_load_OutLow,
   output logic [1:0] SC_STATEMACHINESCROLL_shiftselection_Out,
   output logic [1:0] SC_STATEMACHINESCROLL_level_Out,
   output logic       SC_STATEMACHINESCROLL_gameover_Out,
   output logic [2:0] dbg_state
);

   localparam int                ROW_W       = $clog2(ROWS_PER_LEVEL);
   localparam logic [ROW_W-1:0]  LOAD_MASK   = ROW_W'(ROWS_PER_LOAD - 1);
   localparam logic [TICK_W-1:0] BASE_PERIOD = TICK_W'(PERIOD0);

   logic              clk;
   logic              rst;
   logic              start_n;
   logic              coll_n;
   logic [2:0]        state;
   logic [2:0]        state_next;
   logic [ROW_W-1:0]  row;
   logic [ROW_W-1:0]  row_inc;
   logic [1:0]        level;
   logic [TICK_W-1:0] period;
   logic              tick_done;
   scroll_ctl_t       ctl;

   assign clk     = SC_STATEMACHINESCROLL_CLOCK_50;
   assign rst     = SC_STATEMACHINESCROLL_RESET_InHigh;
   assign start_n = SC_STATEMACHINESCROLL_startButton_InLow;
   assign coll_n  = SC_STATEMACHINESCROLL_collision_InLow;

   assign period  = scroll_period(BASE_PERIOD, level);
   assign row_inc = row + ROW_W'(1);

   // The SHIFT cycle counts as one tick, so shift pulses land a full period apart.
   sc_scrolltick u_tick (
      .clk      (clk),
      .rst      (rst),
      .enable   ((state == ST_RUN) || (state == ST_SHIFT)),
      .clear    (state == ST_INIT),
      .period   (period),
      .terminal (tick_done)
   );

   always_comb begin
      state_next = ST_IDLE;
      case (state)
         ST_RESET:        state_next = ST_IDLE;
         ST_IDLE:         state_next = start_n ? ST_IDLE : ST_INIT;
         ST_INIT:         state_next = ST_WAIT_RELEASE;
         ST_WAIT_RELEASE: state_next = start_n ? ST_RUN : ST_WAIT_RELEASE;
         ST_RUN: begin
            if (!coll_n)        state_next = ST_GAMEOVER;
            else if (tick_done) state_next = ST_SHIFT;
            else                state_next = ST_RUN;
         end
         ST_SHIFT: begin
            if (!coll_n)                         state_next = ST_GAMEOVER;
            else if ((row_inc & LOAD_MASK) == '0) state_next = ST_LOAD;
            else                                 state_next = ST_RUN;
         end
         ST_LOAD:         state_next = coll_n ? ST_RUN : ST_GAMEOVER;
         ST_GAMEOVER:     state_next = start_n ? ST_GAMEOVER : ST_INIT;
         default:         state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RESET;
         row   <= '0;
         level <= '0;
      end else begin
         state <= state_next;
         if (state == ST_INIT) begin
            row   <= '0;
            level <= '0;
         end else if (state == ST_SHIFT) begin
            row <= row_inc;
            if ((row_inc == '0) && (level != LEVEL_MAX)) begin
               level <= level + 2'd1;
            end
         end
      end
   end

   assign ctl = decode_ctl(state);

   assign SC_STATEMACHINESCROLL_clear_OutLow        = ctl.clear_n;
   assign SC_STATEMACHINESCROLL_load_OutLow         = ctl.load_n;
   assign SC_STATEMACHINESCROLL_shiftselection_Out  = ctl.shift_sel;
   assign SC_STATEMACHINESCROLL_gameover_Out        = ctl.gameover;
   assign SC_STATEMACHINESCROLL_level_Out           = level;
   assign dbg_state                                 = state;

endmodule

// File: tb/tb_sc_statemachinescroll.sv
// Scoreboard bench for the scroll FSM: a schedule-based game model predicts
// clear/shift/load/game-over events; a monitor matches them cycle by cycle.
module tb_sc_statemachinescroll;
   import sc_statemachinescroll_pkg::*;

   localparam int P0  = 8;
   localparam int RPL = 4;
   localparam int RPV = 16;

   localparam int EV_CLEAR = 0;
   localparam int EV_SHIFT = 1;
   localparam int EV_LOAD  = 2;
   localparam int EV_OVER  = 3;

   localparam int M_RST   = 0;
   localparam int M_IDLE  = 1;
   localparam int M_CLEAR = 2;
   localparam int M_WAIT  = 3;
   localparam int M_PLAY  = 4;
   localparam int M_OVER  = 5;

   // ---------------- clock / reset / DUT ----------------
   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       start_n = 1'b1;
   logic       coll_n  = 1'b1;
   logic       clear_n;
   logic       load_n;
   logic [1:0] shift_sel;
   logic [1:0] level;
   logic       gameover;
   logic [2:0] dbg_state;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   sc_statemachinescroll #(
      .PERIOD0        (P0),
      .ROWS_PER_LOAD  (RPL),
      .ROWS_PER_LEVEL (RPV)
   ) dut (
      .SC_STATEMACHINESCROLL_CLOCK_50          (clk),
      .SC_STATEMACHINESCROLL_RESET_InHigh      (rst),
      .SC_STATEMACHINESCROLL_startButton_InLow (start_n),
      .SC_STATEMACHINESCROLL_collision_InLow   (coll_n),
      .SC_STATEMACHINESCROLL_clear_OutLow      (clear_n),
      .SC_STATEMACHINESCROLL_load_OutLow       (load_n),
      .SC_STATEMACHINESCROLL_shiftselection_Out(shift_sel),
      .SC_STATEMACHINESCROLL_level_Out         (level),
      .SC_STATEMACHINESCROLL_gameover_Out      (gameover),
      .dbg_state                               (dbg_state)
   );

   // ---------------- scoreboard ----------------
   // Each entry packs {cycle[29:0], event kind[1:0]}.
   logic [31:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic report_fail(input string name, input int act, input int exp);
      n_checks++;
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
   endtask

   task automatic push_ev(input int k, input int kind);
      exp_q.push_back({30'(k), 2'(kind)});
   endtask

   // ---------------- reference model ----------------
   // Game-level view: shifts happen on an absolute-cycle schedule; a period is
   // PERIOD0>>level cycles (never under 2), plus one cycle when a load follows.
   int   m_phase      = M_RST;
   int   m_lvl        = 0;
   int   m_lvl_show   = 0;
   int   m_nshift     = 0;
   int   m_next_shift = 0;
   int   m_load_at    = -1;
   logic m_shift_now  = 1'b0;

   function automatic int shift_gap(input int lvl);
      int p;
      p = P0 >> lvl;
      return (p < 2) ? 2 : p;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_phase      = M_RST;
      m_lvl        = 0;
      m_lvl_show   = 0;
      m_nshift     = 0;
      m_next_shift = 0;
      m_load_at    = -1;
      m_shift_now  = 1'b0;
   endtask

   // Predicts the cycle that follows the inputs just driven.
   task automatic model_step(input logic st, input logic co);
      int k;
      int ld;
      k = cyc + 1;
      m_shift_now = 1'b0;
      case (m_phase)
         M_RST: m_phase = M_IDLE;
         M_IDLE, M_OVER: begin
            if (!st) begin
               m_phase = M_CLEAR;
               push_ev(k, EV_CLEAR);
            end
         end
         M_CLEAR: begin
            m_phase    = M_WAIT;
            m_lvl      = 0;
            m_lvl_show = 0;
         end
         M_WAIT: begin
            if (st) begin
               m_phase      = M_PLAY;
               m_nshift     = 0;
               m_next_shift = k + P0;
               m_load_at    = -1;
            end
         end
         M_PLAY: begin
            m_lvl_show = m_lvl;
            if (!co) begin
               m_phase = M_OVER;
               push_ev(k, EV_OVER);
            end else begin
               if (k == m_load_at) push_ev(k, EV_LOAD);
               if (k == m_next_shift) begin
                  push_ev(k, EV_SHIFT);
                  m_shift_now = 1'b1;
                  m_nshift++;
                  m_lvl = (m_nshift / RPV > 3) ? 3 : m_nshift / RPV;
                  ld = (m_nshift % RPL == 0) ? 1 : 0;
                  if (ld == 1) m_load_at = k + 1;
                  m_next_shift = k + shift_gap(m_lvl) + ld;
               end
            end
         end
         default: m_phase = M_IDLE;
      endcase
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_cycle(input logic st, input logic co);
      @(negedge clk);
      start_n = st;
      coll_n  = co;
      if (!rst) model_step(st, co);
   endtask

   task automatic reset_for(input int n);
      @(negedge clk);
      rst     = 1'b1;
      start_n = 1'b1;
      coll_n  = 1'b1;
      model_reset();
      #1;
      check("rst_clear", int'(clear_n), 1);
      check("rst_load", int'(load_n), 1);
      check("rst_shiftsel", int'(shift_sel), int'(SEL_HOLD));
      check("rst_level", int'(level), 0);
      check("rst_gameover", int'(gameover), 0);
      repeat (n) @(negedge clk);
      rst = 1'b0;
      model_step(1'b1, 1'b1);
   endtask

   // ---------------- monitor ----------------
   logic prev_over = 1'b0;
   int   obs;
   int   n_act;

   initial begin : monitor
      forever begin
         @(posedge clk);
         #1;
         while (exp_q.size() > 0 && int'(exp_q[0][31:2]) < cyc) begin
            report_fail("missed_event", -1, int'(exp_q[0][1:0]));
            void'(exp_q.pop_front());
         end
         obs   = -1;
         n_act = 0;
         if (!clear_n)                   begin obs = EV_CLEAR; n_act++; end
         if (!load_n)                    begin obs = EV_LOAD;  n_act++; end
         if (shift_sel == SEL_DOWN)      begin obs = EV_SHIFT; n_act++; end
         if (gameover && !prev_over)     begin obs = EV_OVER;  n_act++; end
         if (n_act > 1) report_fail("exclusive_pulses", n_act, 1);
         if (obs >= 0) begin
            if (exp_q.size() == 0 || int'(exp_q[0][31:2]) != cyc) begin
               report_fail("unexpected_event", obs, -1);
            end else begin
               check("event_kind", obs, int'(exp_q[0][1:0]));
               void'(exp_q.pop_front());
            end
         end
         check("gameover_level", int'(gameover), (m_phase == M_OVER) ? 1 : 0);
         check("level_out", int'(level), m_lvl_show);
         check("shiftsel_legal", (shift_sel == SEL_HOLD || shift_sel == SEL_DOWN) ? 1 : 0, 1);
         prev_over = gameover;
      end
   end

   // ---------------- stimulus ----------------
   int found;

   initial begin : stimulus
      reset_for(4);

      // Single press, then climb through all speed levels without collision.
      drive_cycle(1'b0, 1'b1);
      for (int i = 0; i < 1500 && m_nshift < 66; i++) drive_cycle(1'b1, 1'b1);
      if (m_nshift < 66) report_fail("level_climb_budget", m_nshift, 66);
      drive_cycle(1'b1, 1'b0);
      repeat (5) drive_cycle(1'b1, 1'b1);

      // New game from GAMEOVER; collide in the tick terminal-count cycle.
      drive_cycle(1'b0, 1'b1);
      drive_cycle(1'b1, 1'b1);
      found = 0;
      for (int i = 0; i < 80; i++) begin
         if (m_phase == M_PLAY && m_next_shift == cyc + 2) begin
            drive_cycle(1'b1, 1'b0);
            found = 1;
            break;
         end
         drive_cycle(1'b1, 1'b1);
      end
      if (found == 0) report_fail("terminal_collision_budget", 0, 1);
      repeat (4) drive_cycle(1'b1, 1'b1);

      // Start held low through INIT, then start pulses while running.
      repeat (7) drive_cycle(1'b0, 1'b1);
      for (int i = 0; i < 60; i++) drive_cycle((i % 5 == 0) ? 1'b0 : 1'b1, 1'b1);

      // Asynchronous reset in the middle of a SHIFT cycle.
      found = 0;
      for (int i = 0; i < 80; i++) begin
         drive_cycle(1'b1, 1'b1);
         if (m_shift_now) begin
            found = 1;
            break;
         end
      end
      if (found == 0) report_fail("shift_wait_budget", 0, 1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("midshift_rst_shiftsel", int'(shift_sel), int'(SEL_HOLD));
      check("midshift_rst_load", int'(load_n), 1);
      check("midshift_rst_clear", int'(clear_n), 1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_step(1'b1, 1'b1);
      drive_cycle(1'b1, 1'b1);
      check("post_rst_state", int'(dbg_state), int'(ST_IDLE));
      drive_cycle(1'b0, 1'b1);
      repeat (30) drive_cycle(1'b1, 1'b1);
      drive_cycle(1'b1, 1'b0);

      // Randomized play: start pulses, holds and collisions.
      for (int i = 0; i < 3000; i++) begin
         drive_cycle(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 59) != 0) ? 1'b1 : 1'b0);
      end
      drive_cycle(1'b1, 1'b0);
      repeat (10) drive_cycle(1'b1, 1'b1);
      @(posedge clk);
      #2;
      check("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
